traffic_light_ctrl: RTL
=======================

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter WDOG_CYCLES, default 31'd1_300_000_000: max cycles to wait for timer_done in any timed state.
REQ-002 Parameter FLASH_HALF, default 31'd25_000_000: half-period, in cycles, of the fault flash.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 timer_done  input  1  one-cycle pulse from the interval timer; the current interval has expired.
REQ-006 start_long  output  1  one-cycle request for a 25 s interval.
REQ-007 start_short  output  1  one-cycle request for a 4 s interval.
REQ-008 ns_light  output  3  north-south lamps {red,yellow,green}, one-hot except in FAULT.
REQ-009 ew_light  output  3  east-west lamps, same encoding.
REQ-010 fault  output  1  high while in FAULT.

Function
REQ-011 States: INIT, NS_GREEN, NS_YELLOW, EW_GREEN, EW_YELLOW, FAULT, plus ALL_RED_A and ALL_RED_B when ALL_RED_EN is defined.
REQ-012 INIT: both red; leave to NS_GREEN on the first clock after reset release.
REQ-013 Lamps: NS_GREEN ns=001, ew=100; NS_YELLOW ns=010, ew=100; EW_GREEN ns=100, ew=001; EW_YELLOW ns=100, ew=010; ALL_RED_x both 100.
REQ-014 Start pulse: registered, high only in the first cycle of a timed state; start_long for *_GREEN; start_short for *_YELLOW and ALL_RED_x.
REQ-015 start_long and start_short are never high together, and at most one start is issued per state visit.
REQ-016 Transition on timer_done only: NS_GREEN->NS_YELLOW->EW_GREEN->EW_YELLOW->NS_GREEN; takes effect on the clock edge sampling the pulse.
REQ-017 timer_done in the first cycle of a state, or in INIT or FAULT, is ignored.
REQ-018 Watchdog: a 31-bit counter clears on each state entry and increments every cycle in a timed state; when it reaches WDOG_CYCLES-1 without timer_done, go to FAULT.
REQ-019 If timer_done and watchdog expiry occur in the same cycle, timer_done wins (normal transition).
REQ-020 FAULT: fault=1; no start pulses; ns_light and ew_light are both 010 and 000, toggling every FLASH_HALF cycles, starting at 010.
REQ-021 FAULT is exited only by rst.

Reset
REQ-022 While rst is high: state=INIT, start_long=0, start_short=0, ns_light=100, ew_light=100, fault=0, watchdog and flash counters=0.
REQ-023 rst asserted mid-interval aborts immediately; no start pulse is emitted during reset or in the cycle it releases.

Configuration
REQ-024 Macro ALL_RED_EN defined: NS_YELLOW->ALL_RED_A->EW_GREEN and EW_YELLOW->ALL_RED_B->NS_GREEN, each ALL_RED state timed by start_short.
REQ-025 ALL_RED_EN undefined: the ALL_RED states are absent and yellow goes directly to the opposing green.

Structure
REQ-026 Shared package traffic_pkg holds the state enum, the lamp constants RED=100, YEL=010, GRN=001, OFF=000, and the 25 s/4 s interval identifiers.
REQ-027 One sub-module, tl_watchdog (clear, enable, expired output), is natural; flash divider and FSM stay in traffic_light_ctrl.

Verification
REQ-028 Reset release, no done -> cycle 1 NS_GREEN with start_long=1 for 1 cycle; ns=001, ew=100.
REQ-029 Bench pulses done 10 cycles after each start -> NS_GREEN, NS_YELLOW (start_short), EW_GREEN (start_long), EW_YELLOW, NS_GREEN, with ALL_RED inserted when ALL_RED_EN is defined.
REQ-030 WDOG_CYCLES=20, no done -> FAULT 20 cycles after NS_GREEN entry; fault=1; lamps 010/000 toggle every FLASH_HALF=4 cycles; extra done pulses are ignored.
REQ-031 WDOG_CYCLES=20, done on cycle 19 together with expiry -> normal transition, fault stays 0.
REQ-032 rst pulsed 5 cycles into EW_GREEN -> immediately INIT with both lamps 100 and no start; NS_GREEN follows after release.
REQ-033 done in the first cycle of NS_YELLOW -> ignored; state is unchanged until the next done pulse.

Source files
------------

// File: rtl/traffic_pkg.sv
// traffic_pkg -- shared types and helpers for the traffic light controller.
//   Lamp encodings are {red,yellow,green}. The state enum gains ALL_RED_A and
//   ALL_RED_B only when the ALL_RED_EN macro is defined.
//   Helpers: is_timed, next_state, interval_of, lamps_of.
package traffic_pkg;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

   // Interval identifiers: IV_LONG = 25 s, IV_SHORT = 4 s.
   typedef enum logic {IV_LONG, IV_SHORT} interval_e;

   typedef enum logic [2:0] {
      INIT      = 3'd0,
      NS_GREEN  = 3'd1,
      NS_YELLOW = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      FAULT     = 3'd5
`ifdef ALL_RED_EN
      , ALL_RED_A = 3'd6,
      ALL_RED_B = 3'd7
`endif
   } state_e;

   // Timed states are the ones waiting on the interval timer.
   function automatic logic is_timed(input state_e s);
      return (s != INIT) && (s != FAULT);
   endfunction

   // Successor of a timed state on timer_done.
   function automatic state_e next_state(input state_e s);
      case (s)
         NS_GREEN:  return NS_YELLOW;
`ifdef ALL_RED_EN
         NS_YELLOW: return ALL_RED_A;
         ALL_RED_A: return EW_GREEN;
         EW_GREEN:  return EW_YELLOW;
         EW_YELLOW: return ALL_RED_B;
         ALL_RED_B: return NS_GREEN;
`else
         NS_YELLOW: return EW_GREEN;
         EW_GREEN:  return EW_YELLOW;
         EW_YELLOW: return NS_GREEN;
`endif
         default:   return NS_GREEN;
      endcase
   endfunction

   function automatic interval_e interval_of(input state_e s);
      return (s == NS_GREEN || s == EW_GREEN) ? IV_LONG : IV_SHORT;
   endfunction

   // {ns_light, ew_light} for every non-fault state.
   function automatic logic [5:0] lamps_of(input state_e s);
      case (s)
         NS_GREEN:  return {GRN, RED};
         NS_YELLOW: return {YEL, RED};
         EW_GREEN:  return {RED, GRN};
         EW_YELLOW: return {RED, YEL};
         default:   return {RED, RED};
      endcase
   endfunction

endpackage

// File: rtl/tl_watchdog.sv
// tl_watchdog -- interval watchdog for the traffic light FSM.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : zero the counter (state entry / leaving timed operation)
//   enable     : count this cycle (FSM is in a timed state)
//   expired    : counter has reached LIMIT-1 while enabled
module tl_watchdog #(
   parameter logic [30:0] LIMIT = 31'd1_300_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [30:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         count <= '0;
      else if (clear)  count <= '0;
      else if (enable) count <= count + 31'd1;
   end

   assign expired = enable && (count == LIMIT - 31'd1);

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl -- two-way intersection controller with watchdog fault.
//   clk, rst     : clock, asynchronous active-high reset
//   timer_done   : one-cycle pulse, current interval expired
//   start_long   : one-cycle request for a 25 s interval (greens)
//   start_short  : one-cycle request for a 4 s interval (yellows, all-reds)
//   ns_light     : north-south lamps {red,yellow,green}
//   ew_light     : east-west lamps {red,yellow,green}
//   fault        : high while in FAULT (yellow flash, exit only by reset)
// Build option: define ALL_RED_EN to insert an all-red phase after each yellow.
module traffic_light_ctrl
   import traffic_pkg::*;
#(
   parameter logic [30:0] WDOG_CYCLES = 31'd1_300_000_000,
   parameter logic [30:0] FLASH_HALF  = 31'd25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       timer_done,
   output logic       start_long,
   output logic       start_short,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic       fault
);

   state_e      state;
   state_e      nxt;
   logic        first;       // high in the first cycle of a state visit
   logic [30:0] flash_cnt;
   logic        timed;
   logic        take;
   logic        wd_expired;

   assign timed = is_timed(state);
   // timer_done is honoured only after the entry cycle of a timed state.
   assign take  = timed && !first && timer_done;
   assign nxt   = (state == INIT) ? NS_GREEN : next_state(state);

   // Clearing on every non-timed cycle means the count is zero on entry to
   // any timed state, including the first one after INIT.
   tl_watchdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (!timed || take),
      .enable  (timed),
      .expired (wd_expired)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= INIT;
         first       <= 1'b0;
         start_long  <= 1'b0;
         start_short <= 1'b0;
         ns_light    <= RED;
         ew_light    <= RED;
         fault       <= 1'b0;
         flash_cnt   <= '0;
      end else begin
         start_long  <= 1'b0;
         start_short <= 1'b0;
         first       <= 1'b0;
         // take is checked before wd_expired so a simultaneous done wins.
         if (state == INIT || take) begin
            state                  <= nxt;
            first                  <= 1'b1;
            start_long             <= (interval_of(nxt) == IV_LONG);
            start_short            <= (interval_of(nxt) == IV_SHORT);
            {ns_light, ew_light}   <= lamps_of(nxt);
         end else if (wd_expired) begin
            state     <= FAULT;
            fault     <= 1'b1;
            ns_light  <= YEL;
            ew_light  <= YEL;
            flash_cnt <= '0;
         end else if (state == FAULT) begin
            if (flash_cnt == FLASH_HALF - 31'd1) begin
               flash_cnt <= '0;
               ns_light  <= ns_light ^ YEL;
               ew_light  <= ew_light ^ YEL;
            end else begin
               flash_cnt <= flash_cnt + 31'd1;
            end
         end
      end
   end

endmodule
